wen_rr_merger: RTL and testbench

Three-channel write merger for the connector datapath. It accepts the three fire-and-forget write channels (wenN/dataN), buffers each in a small per-channel FIFO, and shares one output stream between them. A round-robin arbiter drives the shared stream over a valid/ready handshake, and each beat is tagged with its source channel. The block sits directly downstream of the connector input registers and feeds the single shared consumer.

---
 rtl/wen_merge_pkg.sv | 20 ++
 rtl/chan_fifo.sv | 45 ++++
 rtl/wen_rr_merger.sv | 88 ++++++++
 tb/tb_wen_rr_merger.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wen_merge_pkg.sv
// Shared types and the round-robin grant function for the three-channel write merger.
package wen_merge_pkg;

  localparam int unsigned NUM_CH = 3;

  typedef logic [1:0] ch_id_t;

  // Grant order is last+1, last+2, last (mod NUM_CH); returns last when nothing requests.
  function automatic ch_id_t rr_next(input ch_id_t last, input logic [NUM_CH-1:0] req);
    ch_id_t g;
    ch_id_t c;
    g = last;
    for (int i = int'(NUM_CH); i >= 1; i--) begin
      c = ch_id_t'((32'(last) + 32'(i)) % NUM_CH);
      if (req[c]) g = c;
    end
    return g;
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// Per-channel FIFO; head entry is presented combinationally, push is accepted on full when popped.
module chan_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          wr_en;
  logic          rd_en;

  // Extra wrap bit separates full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en    = pop && !empty;
  assign wr_en    = push && (!full || rd_en);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/wen_rr_merger.sv
// Merges three fire-and-forget write channels onto one valid/ready stream with round-robin arbitration.
module wen_rr_merger
  import wen_merge_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8
) (
  input  logic              clk0,
  input  logic              resetn,
  input  logic              wen0,
  input  logic              wen1,
  input  logic              wen2,
  input  logic [DW-1:0]     data0,
  input  logic [DW-1:0]     data1,
  input  logic [DW-1:0]     data2,
  input  logic              freeze,
  input  logic              out_ready,
  input  logic              ovf_clr,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  output ch_id_t            out_ch,
  output logic [NUM_CH-1:0] ovf,
  output logic              busy
);

  logic [NUM_CH-1:0] wen;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] drop;
  logic [DW-1:0]     wdata [NUM_CH];
  logic [DW-1:0]     head  [NUM_CH];
  ch_id_t            last;
  ch_id_t            grant;
  logic              load;

  assign wen      = {wen2, wen1, wen0};
  assign wdata[0] = data0;
  assign wdata[1] = data1;
  assign wdata[2] = data2;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_fifo
    chan_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
      .clk       (clk0),
      .rst_n     (resetn),
      .push      (wen[n]),
      .push_data (wdata[n]),
      .pop       (pop[n]),
      .pop_data  (head[n]),
      .full      (full[n]),
      .empty     (empty[n])
    );
  end

  // Arbitration: load the output register whenever it is free or draining and not frozen.
  always_comb begin
    req   = ~empty;
    grant = rr_next(last, req);
    load  = (!out_valid || out_ready) && !freeze && (|req);
    pop   = '0;
    if (load) pop[grant] = 1'b1;
    drop  = wen & full & ~pop;
  end

  assign busy = out_valid || (|req);

  always_ff @(posedge clk0 or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ovf       <= '0;
      last      <= 2'd2;
    end else begin
      ovf <= (ovf & ~{NUM_CH{ovf_clr}}) | drop;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= head[grant];
        out_ch    <= grant;
        last      <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wen_rr_merger.sv
// Directed self-checking bench for wen_rr_merger.
module tb_wen_rr_merger;

  logic       clk0 = 1'b0;
  logic       resetn;
  logic       wen0, wen1, wen2;
  logic [7:0] data0, data1, data2;
  logic       freeze, out_ready, ovf_clr;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_ch;
  logic [2:0] ovf;
  logic       busy;

  int tests = 0;
  int fails = 0;

  wen_rr_merger #(.DEPTH(4), .DW(8)) dut (
    .clk0(clk0), .resetn(resetn),
    .wen0(wen0), .wen1(wen1), .wen2(wen2),
    .data0(data0), .data1(data1), .data2(data2),
    .freeze(freeze), .out_ready(out_ready), .ovf_clr(ovf_clr),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .ovf(ovf), .busy(busy)
  );

  always #5 clk0 = ~clk0;

  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    {wen0, wen1, wen2} = 3'b000;
    data0 = 8'h00; data1 = 8'h00; data2 = 8'h00;
    freeze = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk0);
    #1 resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({out_valid, out_data, out_ch, ovf, busy} !== 15'h0) begin
      fails++;
      $display("FAIL reset_state: got v=%b d=%h ch=%0d ovf=%b busy=%b, expected all zero",
               out_valid, out_data, out_ch, ovf, busy);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    out_ready = 1'b1;
    wen1 = 1'b1; data1 = 8'hA5;
    step();
    wen1 = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL single_early: out_valid=%b expected 0", out_valid);
    end
    step();
    tests++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd1, 8'hA5}) begin
      fails++; $display("FAIL single_beat: v=%b ch=%0d d=%h expected v=1 ch=1 d=a5", out_valid, out_ch, out_data);
    end
    step();
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL single_after: v=%b busy=%b expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ch [6];
    logic [7:0] exp_d  [6];
    exp_ch = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    exp_d  = '{8'h10, 8'h20, 8'h30, 8'h11, 8'h21, 8'h31};
    do_reset();
    out_ready = 1'b1;
    {wen0, wen1, wen2} = 3'b111;
    data0 = 8'h10; data1 = 8'h20; data2 = 8'h30;
    step();
    data0 = 8'h11; data1 = 8'h21; data2 = 8'h31;
    step();
    {wen0, wen1, wen2} = 3'b000;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      tests++;
      if ({out_valid, out_ch, out_data} !== {1'b1, exp_ch[k], exp_d[k]}) begin
        fails++;
        $display("FAIL rr_beat%0d: v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                 k, out_valid, out_ch, out_data, exp_ch[k], exp_d[k]);
      end
    end
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL rr_end: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    wen2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data2 = 8'(i);
      step();
    end
    wen2 = 1'b0;
    tests++;
    if ({ovf, out_valid, out_data} !== {3'b100, 1'b1, 8'h00}) begin
      fails++; $display("FAIL ovf_set: ovf=%b v=%b d=%h expected 100 1 00", ovf, out_valid, out_data);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step();
      tests++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 8'(i)}) begin
        fails++; $display("FAIL ovf_drain%0d: v=%b ch=%0d d=%h expected 1 2 %h", i, out_valid, out_ch, out_data, 8'(i));
      end
    end
    step();
    tests++;
    if ({out_valid, ovf} !== {1'b0, 3'b100}) begin
      fails++; $display("FAIL ovf_sticky: v=%b ovf=%b expected 0 100", out_valid, ovf);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    tests++;
    if (ovf !== 3'b000) begin
      fails++; $display("FAIL ovf_clear: ovf=%b expected 000", ovf);
    end
    out_ready = 1'b0;
    wen2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data2 = 8'(i);
      ovf_clr = (i == 5);
      step();
      if (i == 4) begin
        tests++;
        if (ovf !== 3'b000) begin
          fails++; $display("FAIL ovf_refill: ovf=%b expected 000", ovf);
        end
      end
    end
    wen2 = 1'b0; ovf_clr = 1'b0;
    tests++;
    if (ovf !== 3'b100) begin
      fails++; $display("FAIL ovf_set_over_clr: ovf=%b expected 100", ovf);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    wen0 = 1'b1; data0 = 8'h55;
    step();
    wen0 = 1'b0;
    step();
    tests++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 8'h55}) begin
      fails++; $display("FAIL frz_pending: v=%b ch=%0d d=%h expected 1 0 55", out_valid, out_ch, out_data);
    end
    freeze = 1'b1; out_ready = 1'b1;
    {wen0, wen1, wen2} = 3'b111;
    data0 = 8'h44; data1 = 8'h66; data2 = 8'h77;
    step();
    {wen0, wen1, wen2} = 3'b000;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL frz_complete: out_valid=%b expected 0", out_valid);
    end
    repeat (2) step();
    tests++;
    if ({out_valid, busy} !== 2'b01) begin
      fails++; $display("FAIL frz_hold: v=%b busy=%b expected 0 1", out_valid, busy);
    end
    freeze = 1'b0;
    step();
    tests++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd1, 8'h66}) begin
      fails++; $display("FAIL frz_resume1: v=%b ch=%0d d=%h expected 1 1 66", out_valid, out_ch, out_data);
    end
    step();
    tests++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 8'h77}) begin
      fails++; $display("FAIL frz_resume2: v=%b ch=%0d d=%h expected 1 2 77", out_valid, out_ch, out_data);
    end
    step();
    tests++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 8'h44}) begin
      fails++; $display("FAIL frz_resume3: v=%b ch=%0d d=%h expected 1 0 44", out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    wen0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data0 = 8'(8'h80 + i);
      step();
    end
    wen0 = 1'b0;
    tests++;
    if ({out_valid, ovf, busy} !== {1'b1, 3'b001, 1'b1}) begin
      fails++; $display("FAIL rst_pre: v=%b ovf=%b busy=%b expected 1 001 1", out_valid, ovf, busy);
    end
    #1 resetn = 1'b0;
    #1;
    tests++;
    if ({out_valid, ovf, busy} !== 5'b0) begin
      fails++; $display("FAIL rst_async: v=%b ovf=%b busy=%b expected 0 000 0", out_valid, ovf, busy);
    end
    out_ready = 1'b1;
    @(negedge clk0);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({out_valid, busy} !== 2'b00) begin
        fails++; $display("FAIL rst_after%0d: v=%b busy=%b expected 0 0", i, out_valid, busy);
      end
    end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    wen0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data0 = 8'(i);
      step();
    end
    out_ready = 1'b1;
    data0 = 8'h05;
    step();
    wen0 = 1'b0;
    tests++;
    if ({ovf, out_valid, out_data} !== {3'b000, 1'b1, 8'h01}) begin
      fails++; $display("FAIL pp_full: ovf=%b v=%b d=%h expected 000 1 01", ovf, out_valid, out_data);
    end
    for (int i = 2; i < 6; i++) begin
      step();
      tests++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 8'(i)}) begin
        fails++; $display("FAIL pp_drain%0d: v=%b ch=%0d d=%h expected 1 0 %h", i, out_valid, out_ch, out_data, 8'(i));
      end
    end
    step();
    tests++;
    if ({out_valid, ovf, busy} !== 5'b0) begin
      fails++; $display("FAIL pp_end: v=%b ovf=%b busy=%b expected 0 000 0", out_valid, ovf, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_overflow();
    test_freeze();
    test_reset_midstream();
    test_push_pop_full();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
